divider_arbiter: RTL

//  Shares one sequential_divider/reciprocal datapath among NUM_REQ requesters.

---
 rtl/divider_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/divider_arbiter.sv
// ============================================================================
// Module   : divider_arbiter
// Purpose  : Round-robin front end that shares one sequential divider among
//            NUM_REQ requesters and returns ID-tagged fixed-point quotients.
//            Define DIV_ZERO_BYPASS_EN to answer B==0 requests without
//            issuing them to the divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_arbiter #(
    parameter  int ARG_BIT_WIDTH = 32,
    parameter  int PRECISION     = 64,
    parameter  int NUM_REQ       = 4,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*ARG_BIT_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*ARG_BIT_WIDTH-1:0]   req_b,
    output logic                               div_start,
    output logic [ARG_BIT_WIDTH-1:0]           div_a,
    output logic [ARG_BIT_WIDTH-1:0]           div_b,
    input  logic                               div_done,
    input  logic                               div_dz,
    input  logic [ARG_BIT_WIDTH+PRECISION-1:0] div_result,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [ID_W-1:0]                    resp_id,
    output logic [ARG_BIT_WIDTH+PRECISION-1:0] resp_data,
    output logic                               resp_dz,
    output logic                               busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                             r_state;
    state_t                             w_next;
    logic [ID_W-1:0]                    r_ptr;
    logic [ID_W-1:0]                    r_id;
    logic [ID_W-1:0]                    w_gid;
    logic [ID_W:0]                      w_idx;
    logic                               w_found;
    logic                               w_accept;
    logic                               w_zero_bypass;
    logic                               r_wait_first;
    logic [ARG_BIT_WIDTH-1:0]           r_a;
    logic [ARG_BIT_WIDTH-1:0]           r_b;
    logic [ARG_BIT_WIDTH-1:0]           w_sel_a;
    logic [ARG_BIT_WIDTH-1:0]           w_sel_b;
    logic [ARG_BIT_WIDTH+PRECISION-1:0] r_data;
    logic                               r_dz;

    // First valid requester at or after r_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_gid   = w_idx[ID_W-1:0];
            end
        end
    end

    // Qualified by rst_n so no grant is visible while reset is held.
    assign w_accept  = (r_state == S_IDLE) && w_found && rst_n;
    assign req_ready = w_accept ? (NUM_REQ'(1) << w_gid) : '0;
    assign w_sel_a   = req_a[int'(w_gid)*ARG_BIT_WIDTH +: ARG_BIT_WIDTH];
    assign w_sel_b   = req_b[int'(w_gid)*ARG_BIT_WIDTH +: ARG_BIT_WIDTH];

`ifdef DIV_ZERO_BYPASS_EN
    assign w_zero_bypass = (w_sel_b == '0);
`else
    assign w_zero_bypass = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        div_start  = 1'b0;
        resp_valid = 1'b0;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_zero_bypass ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                div_start = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                // A done still high from the previous operation is skipped.
                if (!r_wait_first && div_done) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_id         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_data       <= '0;
            r_dz         <= 1'b0;
            r_wait_first <= 1'b0;
        end else begin
            r_wait_first <= (r_state == S_ISSUE);
            if (w_accept) begin
                r_a   <= w_sel_a;
                r_b   <= w_sel_b;
                r_id  <= w_gid;
                r_ptr <= (w_gid == ID_W'(NUM_REQ-1)) ? '0 : w_gid + ID_W'(1);
                if (w_zero_bypass) begin
                    r_data <= '0;
                    r_dz   <= 1'b1;
                end
            end
            if ((r_state == S_WAIT) && !r_wait_first && div_done) begin
                r_dz   <= div_dz;
                r_data <= div_dz ? '0 : div_result;
            end
        end
    end

    assign div_a     = r_a;
    assign div_b     = r_b;
    assign resp_id   = r_id;
    assign resp_data = r_data;
    assign resp_dz   = r_dz;

endmodule

`default_nettype wire
